// File: rtl/poly_feeder_pkg.sv
// Shared types and constants for the poly_feeder host-side evaluator driver.
// Used by poly_feeder, go_pulse_gen and the poly_feeder_if users.
package poly_feeder_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE     = 3'd0;
    localparam state_t SETUP    = 3'd1;
    localparam state_t PULSE    = 3'd2;
    localparam state_t HOLD     = 3'd3;
    localparam state_t WAIT_RES = 3'd4;
    localparam state_t RESP     = 3'd5;

    typedef logic [1:0] idx_t;

    localparam idx_t IDX_A = 2'd0;
    localparam idx_t IDX_B = 2'd1;
    localparam idx_t IDX_C = 2'd2;
    localparam idx_t IDX_X = 2'd3;

    localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
    } req_t;

    function automatic logic [7:0] sel_coef(input req_t r, input idx_t i);
        case (i)
            IDX_A:   return r.a;
            IDX_B:   return r.b;
            IDX_C:   return r.c;
            default: return r.x;
        endcase
    endfunction

endpackage

// File: rtl/poly_feeder_if.sv
// Request, evaluator-side and response signals of poly_feeder.
// master = the feeder itself; slave = host plus evaluator side.
interface poly_feeder_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [7:0] req_c;
    logic [7:0] req_x;
    logic       go;
    logic [7:0] data_out;
    logic       result_valid;
    logic [7:0] data_result;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] resp_data;
    logic       resp_err;

    modport master (
        input  req_valid, req_a, req_b, req_c, req_x,
        input  result_valid, data_result, resp_ready,
        output req_ready, go, data_out, resp_valid, resp_data, resp_err
    );

    modport slave (
        output req_valid, req_a, req_b, req_c, req_x,
        output result_valid, data_result, resp_ready,
        input  req_ready, go, data_out, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/poly_feeder_go_pulse_gen.sv
// go_pulse_gen: one byte transfer = SETUP (1) + PULSE (GO_HIGH_CYCLES) + HOLD (1).
// A start seen during HOLD chains straight into the next SETUP.
module go_pulse_gen
    import poly_feeder_pkg::*;
#(
    parameter int GO_HIGH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] byte_in,
    output logic       go,
    output logic [7:0] data_out,
    output logic       done
);

    localparam int CW = (GO_HIGH_CYCLES > 1) ? $clog2(GO_HIGH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(GO_HIGH_CYCLES - 1);

    state_t        phase;
    logic [CW-1:0] cnt;
    logic [7:0]    data_q;

    // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase  <= IDLE;
            cnt    <= '0;
            data_q <= 8'h00;
        end else begin
            case (phase)
                IDLE, HOLD: begin
                    if (start) begin
                        data_q <= byte_in;
                        phase  <= SETUP;
                    end else begin
                        phase  <= IDLE;
                    end
                end
                SETUP: begin
                    cnt   <= '0;
                    phase <= PULSE;
                end
                PULSE: begin
                    if (cnt == CNT_LAST) phase <= HOLD;
                    else                 cnt   <= cnt + CW'(1);
                end
                default: phase <= IDLE;
            endcase
        end
    end

    // data_out stays on data_q through HOLD: the evaluator still loads in the go-fall cycle.
    assign go       = (phase == PULSE);
    assign data_out = data_q;
    assign done     = (phase == HOLD);

endmodule

// File: rtl/poly_feeder.sv
// poly_feeder: serializes {A,B,C,X} to the quadratic evaluator and returns its result.
// Optional result-wait timeout: define POLY_FEEDER_TIMEOUT_EN.
module poly_feeder
    import poly_feeder_pkg::*;
#(
    parameter int GO_HIGH_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         resetn,
    poly_feeder_if.master bus,
    output logic         primed
);

    state_t     state;
    idx_t       idx;
    req_t       req_q;
    logic       awake;
    logic       accept;
    logic       resp_valid_q;
    logic [7:0] resp_data_q;
    logic       gen_start;
    logic       gen_done;
    logic [7:0] gen_byte;

`ifdef POLY_FEEDER_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] tcnt;
    logic           resp_err_q;
`endif

    // awake keeps req_ready low during the reset cycle itself.
    assign bus.req_ready = awake && (state == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // The top stays in SETUP while go_pulse_gen runs the per-byte SETUP/PULSE/HOLD.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        gen_byte  = bus.req_a;
        gen_start = 1'b0;
        if (state == IDLE) begin
            gen_start = accept;
        end else if (state == SETUP) begin
            gen_byte  = sel_coef(req_q, idx_t'(idx + 2'd1));
            gen_start = gen_done && (idx != IDX_X);
        end
    end

    go_pulse_gen #(
        .GO_HIGH_CYCLES(GO_HIGH_CYCLES)
    ) u_go_pulse_gen (
        .clk     (clk),
        .resetn  (resetn),
        .start   (gen_start),
        .byte_in (gen_byte),
        .go      (bus.go),
        .data_out(bus.data_out),
        .done    (gen_done)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            idx          <= IDX_A;
            req_q        <= '0;
            awake        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            primed       <= 1'b0;
`ifdef POLY_FEEDER_TIMEOUT_EN
            tcnt         <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            awake <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= '{a: bus.req_a, b: bus.req_b, c: bus.req_c, x: bus.req_x};
                        idx   <= IDX_A;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (gen_done) begin
                        if (idx == IDX_X) begin
                            state <= WAIT_RES;
`ifdef POLY_FEEDER_TIMEOUT_EN
                            tcnt  <= '0;
`endif
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                WAIT_RES: begin
                    // result_valid is only honoured here; it stays high while the evaluator is parked.
                    if (bus.result_valid) begin
                        resp_data_q  <= bus.data_result;
                        resp_valid_q <= 1'b1;
                        primed       <= 1'b1;
                        state        <= RESP;
`ifdef POLY_FEEDER_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
                    end else if (tcnt == T_LAST) begin
                        resp_data_q  <= TIMEOUT_DATA;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        primed       <= 1'b0;
                        state        <= RESP;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
`endif
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
`ifdef POLY_FEEDER_TIMEOUT_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_poly_feeder.sv
// Directed bench for poly_feeder with a behavioural quadratic evaluator on the go/data side.
// Define POLY_FEEDER_TIMEOUT_EN to also exercise the result-wait timeout.
module tb_poly_feeder;

    logic clk = 1'b0;
    logic resetn;
    logic primed;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    poly_feeder_if bus();

    poly_feeder #(
        .GO_HIGH_CYCLES(2),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus),
        .primed(primed)
    );

    // Evaluator model: a byte completes in the cycle go falls; result 6 cycles after X,
    // then result_valid stays high until the next go (the A transfer acknowledges it).
    logic [7:0] ev_a, ev_b, ev_c, ev_x;
    logic [1:0] ev_cnt;
    logic       ev_go_q;
    logic       ev_busy;
    int         ev_wait;
    logic       eval_dead = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            ev_cnt           <= 2'd0;
            ev_go_q          <= 1'b0;
            ev_busy          <= 1'b0;
            ev_wait          <= 0;
            bus.result_valid <= 1'b0;
            bus.data_result  <= 8'h00;
        end else begin
            ev_go_q <= bus.go;
            if (bus.go) bus.result_valid <= 1'b0;
            if (ev_go_q && !bus.go) begin
                case (ev_cnt)
                    2'd0: ev_a <= bus.data_out;
                    2'd1: ev_b <= bus.data_out;
                    2'd2: ev_c <= bus.data_out;
                    default: begin
                        ev_x    <= bus.data_out;
                        ev_busy <= 1'b1;
                        ev_wait <= 0;
                    end
                endcase
                ev_cnt <= ev_cnt + 2'd1;
            end
            if (ev_busy) begin
                if (ev_wait == 5) begin
                    ev_busy <= 1'b0;
                    if (!eval_dead) begin
                        bus.result_valid <= 1'b1;
                        bus.data_result  <= ev_a * ev_x * ev_x + ev_b * ev_x + ev_c;
                    end
                end else begin
                    ev_wait <= ev_wait + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one request from a negedge and waits for resp_valid (or stop_go go-high samples).
    task automatic run_req(input logic [7:0] a, b, c, x, input int stop_go,
                           output int lat, output int go_hi,
                           output logic [31:0] seen, output logic rv_ack);
        int   pulse;
        logic prev_go;
        pulse   = 0;
        prev_go = 1'b0;
        go_hi   = 0;
        seen    = '0;
        rv_ack  = 1'bx;
        check("req_ready_idle", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a = a; bus.req_b = b; bus.req_c = c; bus.req_x = x;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_a = 8'h00; bus.req_b = 8'h00; bus.req_c = 8'h00; bus.req_x = 8'h00;
        check("req_ready_busy", bus.req_ready, 0);
        while (!bus.resp_valid && lat < 200) begin
            if (bus.go) begin
                if (!prev_go && pulse < 4) begin
                    seen[31 - 8*pulse -: 8] = bus.data_out;
                    pulse++;
                end
                go_hi++;
                if (go_hi == 2) rv_ack = bus.result_valid;
                if (stop_go != 0 && go_hi == stop_go) break;
            end
            prev_go = bus.go;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("wait_bound", (lat < 200), 1);
    endtask

    task automatic consume();
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("resp_cleared", bus.resp_valid, 0);
        check("req_ready_after_resp", bus.req_ready, 1);
    endtask

    task automatic txn(input string tag, input logic [7:0] a, b, c, x, input logic [7:0] exp);
        int          lat, go_hi;
        logic [31:0] seen;
        logic        rv_ack;
        run_req(a, b, c, x, 0, lat, go_hi, seen, rv_ack);
        check({tag, "_latency"}, lat, 24);
        check({tag, "_data"}, bus.resp_data, exp);
        check({tag, "_err"}, bus.resp_err, 0);
        check({tag, "_go_cycles"}, go_hi, 8);
        check({tag, "_bytes"}, seen, {a, b, c, x});
        check({tag, "_primed"}, primed, 1);
    endtask

    initial begin
        int          lat, go_hi;
        logic [31:0] seen;
        logic        rv_ack;

        resetn = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a = 8'h00; bus.req_b = 8'h00; bus.req_c = 8'h00; bus.req_x = 8'h00;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_go", bus.go, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_primed", primed, 0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // 1*16 + 2*4 + 3 = 27
        txn("t1", 8'd1, 8'd2, 8'd3, 8'd4, 8'h1B);
        consume();

        // Back-to-back while the evaluator is parked: A pulse must release result_valid.
        check("eval_parked", bus.result_valid, 1);
        run_req(8'd2, 8'd3, 8'd5, 8'd10, 0, lat, go_hi, seen, rv_ack);
        check("t2_latency", lat, 24);
        check("t2_data", bus.resp_data, 8'hEB);
        check("t2_ack_release", rv_ack, 0);
        check("t2_bytes", seen, {8'd2, 8'd3, 8'd5, 8'd10});
        consume();

        // 16*16 + 1 = 257 -> 0x01 ; x = 0 -> C
        txn("t3", 8'd16, 8'd0, 8'd1, 8'd4, 8'h01);
        consume();
        txn("t4", 8'd7, 8'd9, 8'h42, 8'd0, 8'h42);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_resp_valid", bus.resp_valid, 1);
            check("stall_resp_data", bus.resp_data, 8'h42);
            check("stall_req_ready", bus.req_ready, 0);
            check("stall_go", bus.go, 0);
        end
        consume();

        // Reset during the C pulse (fifth go-high sample).
        run_req(8'd5, 8'd6, 8'd7, 8'd8, 5, lat, go_hi, seen, rv_ack);
        check("mid_go_high", bus.go, 1);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_go", bus.go, 0);
        check("mid_rst_primed", primed, 0);
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_req_ready", bus.req_ready, 0);
        resetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_idle_ready", bus.req_ready, 1);
        check("mid_idle_go", bus.go, 0);
        txn("t5", 8'd1, 8'd1, 8'd1, 8'd1, 8'h03);
        consume();

`ifdef POLY_FEEDER_TIMEOUT_EN
        // Dead evaluator: 1 accept + 16 transfer + 64 wait cycles.
        eval_dead = 1'b1;
        run_req(8'd1, 8'd2, 8'd3, 8'd4, 0, lat, go_hi, seen, rv_ack);
        check("to_latency", lat, 81);
        check("to_data", bus.resp_data, 8'hFF);
        check("to_err", bus.resp_err, 1);
        check("to_primed", primed, 0);
        consume();
        eval_dead = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
